// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction-fetch front end: PC register, combinational imem
//            read, in-order {PC, instr} queue with redirect flush and
//            valid/ready back-pressure. Optional macro FETCH_ALIGN_CHECK_EN
//            adds a sticky misaligned-redirect error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               misalign_err
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
    logic [INSTR_W-1:0] r_q_instr [DEPTH];

    logic               w_nonempty;
    logic               w_pop;
    logic               w_push;
    logic [ADDR_W-1:0]  w_redirect_aligned;

    assign w_nonempty         = (r_count != '0);
    assign w_pop              = w_nonempty & out_ready & ~redirect_valid;
    assign w_push             = ~redirect_valid & ((r_count < c_CNT_W'(DEPTH)) | w_pop);
    assign w_redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign imem_addr = r_pc;
    // Redirect masks the head combinationally so a squashed entry is never consumed.
    assign out_valid = w_nonempty & ~redirect_valid;
    assign out_pc    = w_nonempty ? r_q_pc[r_rd_ptr]    : '0;
    assign out_instr = w_nonempty ? r_q_instr[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_aligned;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: reads are gated by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= imem_data;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`endif

endmodule

`default_nettype wire
